// File: rtl/rv32im_muldiv_arbiter_if.sv
// Requester, response and muldiv-side signals of the two-port muldiv arbiter.
// The arbiter connects through the slave modport; requesters and the muldiv model drive the master side.
interface rv32im_muldiv_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            req0_valid_i;
  logic [2:0]      req0_op_i;
  logic [XLEN-1:0] req0_a_i;
  logic [XLEN-1:0] req0_b_i;
  logic            req0_ready_o;
  logic            req1_valid_i;
  logic [2:0]      req1_op_i;
  logic [XLEN-1:0] req1_a_i;
  logic [XLEN-1:0] req1_b_i;
  logic            req1_ready_o;

  logic            rsp0_valid_o;
  logic [XLEN-1:0] rsp0_data_o;
  logic            rsp0_err_o;
  logic            rsp0_ack_i;
  logic            rsp1_valid_o;
  logic [XLEN-1:0] rsp1_data_o;
  logic            rsp1_err_o;
  logic            rsp1_ack_i;

  logic            md_start_o;
  logic [2:0]      md_op_o;
  logic [XLEN-1:0] md_op1_o;
  logic [XLEN-1:0] md_op2_o;
  logic            md_busy_i;
  logic            md_done_i;
  logic [XLEN-1:0] md_result_i;
  logic            md_ack_o;
  logic            md_clear_o;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_data_o, rsp0_err_o,
    output rsp1_valid_o, rsp1_data_o, rsp1_err_o,
    input  rsp0_ack_i, rsp1_ack_i,
    output md_start_o, md_op_o, md_op1_o, md_op2_o, md_ack_o, md_clear_o,
    input  md_busy_i, md_done_i, md_result_i
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_data_o, rsp0_err_o,
    input  rsp1_valid_o, rsp1_data_o, rsp1_err_o,
    output rsp0_ack_i, rsp1_ack_i,
    input  md_start_o, md_op_o, md_op1_o, md_op2_o, md_ack_o, md_clear_o,
    output md_busy_i, md_done_i, md_result_i
  );
endinterface

// File: rtl/rv32im_muldiv_arbiter.sv
// Round-robin arbiter sharing one RV32M muldiv unit between two requesters,
// one operation in flight, with a watchdog that aborts a stalled unit.
module rv32im_muldiv_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 127
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  rv32im_muldiv_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ptr;
  logic                  r_owner;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_op;
  logic [XLEN-1:0]       r_op1;
  logic [XLEN-1:0]       r_op2;
  logic [1:0][XLEN-1:0]  r_rsp_data;
  logic [1:0]            r_rsp_err;

  logic                  w_grant_idx;
  logic                  w_timeout;
  logic                  w_owner_ack;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_rsp_take;
  logic                  w_unused_busy;

  // busy is informational only; md_done_i alone ends the wait
  assign w_unused_busy = bus.md_busy_i;

  // pointer breaks ties; a lone requester always wins
  assign w_grant_idx = (bus.req0_valid_i && bus.req1_valid_i) ? r_ptr : bus.req1_valid_i;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT));
  assign w_owner_ack = r_owner ? bus.rsp1_ack_i : bus.rsp0_ack_i;

  always_ff @(posedge clk_i) begin
    if (clear_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_rsp_take  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req0_valid_i || bus.req1_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        // a result arriving on the timeout cycle wins over the abort
        if (bus.md_done_i) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_owner_ack) begin
          w_rsp_take  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      w_rsp_take  = 1'b0;
    end
  end

  // operation latch, watchdog counter, response registers and pointer
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant_idx;
        if (w_grant_idx) begin
          r_op  <= bus.req1_op_i;
          r_op1 <= bus.req1_a_i;
          r_op2 <= bus.req1_b_i;
        end else begin
          r_op  <= bus.req0_op_i;
          r_op1 <= bus.req0_a_i;
          r_op2 <= bus.req0_b_i;
        end
      end
      r_cnt <= (r_state == WAIT) ? r_cnt + CNT_W'(1) : '0;
      if (w_done) begin
        r_rsp_data[r_owner] <= bus.md_result_i;
        r_rsp_err[r_owner]  <= 1'b0;
      end else if (w_abort) begin
        r_rsp_data[r_owner] <= '1;
        r_rsp_err[r_owner]  <= 1'b1;
      end
      if (w_rsp_take) r_ptr <= ~r_owner;
    end
  end

  assign bus.req0_ready_o = w_accept & ~w_grant_idx;
  assign bus.req1_ready_o = w_accept &  w_grant_idx;

  assign bus.md_start_o = (r_state == ISSUE) & ~clear_i;
  assign bus.md_op_o    = clear_i ? 3'd0 : r_op;
  assign bus.md_op1_o   = clear_i ? '0 : r_op1;
  assign bus.md_op2_o   = clear_i ? '0 : r_op2;
  assign bus.md_ack_o   = w_done;
  assign bus.md_clear_o = clear_i | w_abort;

  assign bus.rsp0_valid_o = (r_state == RESP) & ~r_owner & ~clear_i;
  assign bus.rsp1_valid_o = (r_state == RESP) &  r_owner & ~clear_i;
  assign bus.rsp0_data_o  = clear_i ? '0 : r_rsp_data[0];
  assign bus.rsp1_data_o  = clear_i ? '0 : r_rsp_data[1];
  assign bus.rsp0_err_o   = r_rsp_err[0] & ~clear_i;
  assign bus.rsp1_err_o   = r_rsp_err[1] & ~clear_i;

endmodule
